// File: rtl/dm_store_ctrl.sv
`timescale 1ns/1ps
// Sub-word store controller: SW writes directly, SB/SH do read-merge-write on a
// word-wide memory; misaligned or reserved stores are rejected with a pulse.
module dm_store_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_req,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 2;

  localparam logic [OPW-1:0] OP_SB  = 2'b00;
  localparam logic [OPW-1:0] OP_SH  = 2'b01;
  localparam logic [OPW-1:0] OP_SW  = 2'b10;
  localparam logic [OPW-1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MRG  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           mem_re_q, mem_re_d;
  logic           mem_we_q, mem_we_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           reject;
  logic [DW-1:0]  merged;

  assign reject = (st_op == OP_RSV)
               || ((st_op == OP_SH) && st_addr[0])
               || ((st_op == OP_SW) && (st_addr[1:0] != 2'b00));

  // Overlay the captured store data onto the returned word, little-endian lanes.
  always_comb begin
    merged = mem_rdata;
    case (op_q)
      OP_SB: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = data_q[7:0];
          2'd1:    merged[15:8]  = data_q[7:0];
          2'd2:    merged[23:16] = data_q[7:0];
          default: merged[31:24] = data_q[7:0];
        endcase
      end
      OP_SH: begin
        if (addr_q[1]) merged[31:16] = data_q[15:0];
        else           merged[15:0]  = data_q[15:0];
      end
      default: merged = data_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (st_req) begin
          op_d        = st_op;
          addr_d      = st_addr;
          data_d      = st_wdata;
          mem_wdata_d = st_wdata;
          if (reject)               state_d = S_ERR;
          else if (st_op == OP_SW)  state_d = S_WR;
          else                      state_d = S_RD;
        end
      end
      S_RD:   state_d = S_MRG;
      S_MRG: begin
        mem_wdata_d = merged;
        state_d     = S_WR;
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered from the state being entered.
    mem_re_d = (state_d == S_RD);
    mem_we_d = (state_d == S_WR);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign st_busy   = busy_q;
  assign st_done   = done_q;
  assign st_err    = err_q;

endmodule

// File: tb/tb_dm_store_ctrl.sv
`timescale 1ns/1ps
// Bench for dm_store_ctrl: word memory model plus a byte-arithmetic reference
// of store results and cycle latencies.
module tb_dm_store_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_req = 1'b0;
  logic [1:0]  st_op = 2'b00;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we, st_busy, st_done, st_err;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int checks = 0;
  int failures = 0;
  int overlap = 0;
  int we_total = 0;

  int r_re, r_we, r_done, r_err, r_nre, r_nwe, r_ndone, r_nerr;
  logic [31:0] r_re_addr, r_we_addr, r_we_data;
  logic [8:0]  r_busy;

  dm_store_ctrl dut (
    .clk(clk), .rst(rst), .st_req(st_req), .st_op(st_op), .st_addr(st_addr),
    .st_wdata(st_wdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .st_busy(st_busy), .st_done(st_done),
    .st_err(st_err)
  );

  always #5 clk = ~clk;

  // Memory returns read data one cycle after mem_re; writes land on the strobe edge.
  always @(posedge clk) begin
    if (mem_re && mem_we) overlap++;
    if (mem_we) we_total++;
    if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
  end

  function automatic logic [31:0] model_word(input logic [1:0] op, input logic [31:0] addr,
                                             input logic [31:0] old, input logic [31:0] wd);
    int sh;
    case (op)
      2'b00: begin
        sh = 8 * int'(addr[1:0]);
        return (old & ~(32'h0000_00FF << sh)) | ((wd & 32'h0000_00FF) << sh);
      end
      2'b01: begin
        sh = addr[1] ? 16 : 0;
        return (old & ~(32'h0000_FFFF << sh)) | ((wd & 32'h0000_FFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  function automatic bit model_reject(input logic [1:0] op, input logic [31:0] addr);
    return (op == 2'b11) || (op == 2'b01 && addr[0]) || (op == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  // Issue one request (edge 0) and record what happens in cycles 1..8.
  task automatic run_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    st_req = 1'b1; st_op = op; st_addr = addr; st_wdata = wd;
    @(posedge clk); #1;
    st_req = 1'b0; st_op = 2'($urandom); st_addr = $urandom; st_wdata = $urandom;
    r_re = -1; r_we = -1; r_done = -1; r_err = -1;
    r_nre = 0; r_nwe = 0; r_ndone = 0; r_nerr = 0; r_busy = '0;
    r_re_addr = '0; r_we_addr = '0; r_we_data = '0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_re)  begin r_re = c; r_nre++; r_re_addr = mem_addr; end
      if (mem_we)  begin r_we = c; r_nwe++; r_we_addr = mem_addr; r_we_data = mem_wdata; end
      if (st_done) begin r_done = c; r_ndone++; end
      if (st_err)  begin r_err = c; r_nerr++; end
      r_busy[c] = st_busy;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({mem_re, mem_we, st_busy, st_done, st_err, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got re=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h, want all 0",
               mem_re, mem_we, st_busy, st_done, st_err, mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sw();
    run_store(2'b10, 32'h100, 32'hDEADBEEF);
    ref_mem[8'h40] = 32'hDEADBEEF;
    checks++;
    if ({r_we, r_done, r_nre, r_nwe} !== {32'sd1, 32'sd2, 32'sd0, 32'sd1}) begin
      failures++; $display("FAIL sw_timing: we=%0d done=%0d nre=%0d nwe=%0d, want 1 2 0 1", r_we, r_done, r_nre, r_nwe);
    end
    checks++;
    if ({r_we_addr, r_we_data} !== {32'h100, 32'hDEADBEEF}) begin
      failures++; $display("FAIL sw_data: addr=%h data=%h, want 00000100 deadbeef", r_we_addr, r_we_data);
    end
    checks++;
    if (r_busy !== 9'b0_0000_0110) begin
      failures++; $display("FAIL sw_busy: mask=%b, want 000000110", r_busy);
    end
  endtask

  task automatic test_sb();
    mem[8'h80] = 32'h11223344; ref_mem[8'h80] = 32'h11223344;
    run_store(2'b00, 32'h203, 32'hFFFFFFAA);
    ref_mem[8'h80] = 32'hAA223344;
    checks++;
    if ({r_re, r_we, r_done} !== {32'sd1, 32'sd3, 32'sd4}) begin
      failures++; $display("FAIL sb_timing: re=%0d we=%0d done=%0d, want 1 3 4", r_re, r_we, r_done);
    end
    checks++;
    if ({r_re_addr, r_we_addr, r_we_data} !== {32'h200, 32'h200, 32'hAA223344}) begin
      failures++; $display("FAIL sb_data: raddr=%h waddr=%h data=%h, want 200 200 aa223344", r_re_addr, r_we_addr, r_we_data);
    end
    checks++;
    if (mem[8'h80] !== 32'hAA223344) begin
      failures++; $display("FAIL sb_mem: got %h, want aa223344", mem[8'h80]);
    end
  endtask

  task automatic test_sh();
    mem[8'h80] = 32'h11223344; ref_mem[8'h80] = 32'h11223344;
    run_store(2'b01, 32'h202, 32'h0000BEEF);
    ref_mem[8'h80] = 32'hBEEF3344;
    checks++;
    if ({r_we, r_we_data, r_done} !== {32'sd3, 32'hBEEF3344, 32'sd4}) begin
      failures++; $display("FAIL sh_merge: we=%0d data=%h done=%0d, want 3 beef3344 4", r_we, r_we_data, r_done);
    end
    run_store(2'b01, 32'h201, 32'h0000BEEF);
    checks++;
    if ({r_err, r_nerr, r_nre, r_nwe, r_ndone} !== {32'sd1, 32'sd1, 32'sd0, 32'sd0, 32'sd0}) begin
      failures++; $display("FAIL sh_misaligned: err=%0d nerr=%0d nre=%0d nwe=%0d ndone=%0d, want 1 1 0 0 0",
                           r_err, r_nerr, r_nre, r_nwe, r_ndone);
    end
  endtask

  task automatic test_errors();
    run_store(2'b11, 32'h100, 32'h12345678);
    checks++;
    if ({r_err, r_nerr, r_nwe, r_nre, r_busy} !== {32'sd1, 32'sd1, 32'sd0, 32'sd0, 9'b0_0000_0010}) begin
      failures++; $display("FAIL reserved_op: err=%0d nerr=%0d nwe=%0d nre=%0d busy=%b, want 1 1 0 0 000000010",
                           r_err, r_nerr, r_nwe, r_nre, r_busy);
    end
    run_store(2'b10, 32'h102, 32'h12345678);
    checks++;
    if ({r_err, r_nerr, r_nwe, r_nre} !== {32'sd1, 32'sd1, 32'sd0, 32'sd0}) begin
      failures++; $display("FAIL sw_misaligned: err=%0d nerr=%0d nwe=%0d nre=%0d, want 1 1 0 0", r_err, r_nerr, r_nwe, r_nre);
    end
    checks++;
    if (mem[8'h40] !== ref_mem[8'h40]) begin
      failures++; $display("FAIL err_mem_untouched: got %h, want %h", mem[8'h40], ref_mem[8'h40]);
    end
  endtask

  task automatic test_busy_ignore();
    int nwe, ndone;
    logic [31:0] wd;
    wd = $urandom;
    nwe = 0; ndone = 0;
    @(negedge clk);
    st_req = 1'b1; st_op = 2'b00; st_addr = 32'h241; st_wdata = wd;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we) nwe++;
      if (st_done) ndone++;
      st_req = (c <= 4); st_op = 2'b10; st_addr = 32'h100; st_wdata = 32'h0BAD0BAD;
      @(posedge clk); #1;
    end
    st_req = 1'b0;
    ref_mem[8'h90] = model_word(2'b00, 32'h241, ref_mem[8'h90], wd);
    checks++;
    if ({nwe, ndone} !== {32'sd1, 32'sd1}) begin
      failures++; $display("FAIL busy_ignore_count: nwe=%0d ndone=%0d, want 1 1", nwe, ndone);
    end
    checks++;
    if ({mem[8'h90], mem[8'h40]} !== {ref_mem[8'h90], ref_mem[8'h40]}) begin
      failures++; $display("FAIL busy_ignore_mem: got %h %h, want %h %h", mem[8'h90], mem[8'h40], ref_mem[8'h90], ref_mem[8'h40]);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] we_mask, err_mask;
    logic [31:0] wd;
    wd = $urandom;
    we_mask = '0; err_mask = '0;
    @(negedge clk);
    st_req = 1'b1; st_op = 2'b10; st_addr = 32'h104; st_wdata = wd;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      we_mask[c] = mem_we;
      if (c == 8) st_req = 1'b0;
      @(posedge clk); #1;
    end
    ref_mem[8'h41] = wd;
    checks++;
    if (we_mask !== 9'b0_1001_0010) begin
      failures++; $display("FAIL b2b_sw_we: mask=%b, want 010010010", we_mask);
    end
    @(negedge clk);
    st_req = 1'b1; st_op = 2'b11; st_addr = 32'h0;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      err_mask[c] = st_err;
      if (c == 8) st_req = 1'b0;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (err_mask !== 9'b0_1010_1010) begin
      failures++; $display("FAIL b2b_err: mask=%b, want 010101010", err_mask);
    end
  endtask

  task automatic test_reset_mid();
    for (int abort = 2; abort <= 3; abort++) begin
      int we_before;
      logic [31:0] wd;
      wd = $urandom;
      @(negedge clk);
      st_req = 1'b1; st_op = 2'b00; st_addr = 32'h222; st_wdata = wd;
      @(posedge clk); #1;
      st_req = 1'b0;
      for (int c = 1; c < abort; c++) begin @(posedge clk); #1; end
      we_before = we_total;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({mem_re, mem_we, st_busy, st_done, st_err, mem_addr, mem_wdata} !== '0) begin
        failures++;
        $display("FAIL reset_mid_c%0d: re=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h, want all 0",
                 abort, mem_re, mem_we, st_busy, st_done, st_err, mem_addr, mem_wdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({we_total - we_before, mem[8'h88]} !== {32'sd0, ref_mem[8'h88]}) begin
        failures++; $display("FAIL reset_mid_abort_c%0d: writes=%0d mem=%h, want 0 %h",
                             abort, we_total - we_before, mem[8'h88], ref_mem[8'h88]);
      end
    end
    run_store(2'b10, 32'h100, 32'hDEADBEEF);
    ref_mem[8'h40] = 32'hDEADBEEF;
    checks++;
    if ({r_we, r_done, r_we_addr, r_we_data} !== {32'sd1, 32'sd2, 32'h100, 32'hDEADBEEF}) begin
      failures++; $display("FAIL reset_then_sw: we=%0d done=%0d addr=%h data=%h, want 1 2 100 deadbeef",
                           r_we, r_done, r_we_addr, r_we_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op;
      logic [31:0] addr, wd, expw;
      logic [7:0]  idx;
      int exp_re, exp_we;
      op   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd   = $urandom;
      idx  = addr[9:2];
      run_store(op, addr, wd);
      if (model_reject(op, addr)) begin
        checks++;
        if ({r_err, r_nerr, r_nre, r_nwe, r_ndone} !== {32'sd1, 32'sd1, 32'sd0, 32'sd0, 32'sd0}) begin
          failures++; $display("FAIL rand_reject op=%0d addr=%h: err=%0d nerr=%0d nre=%0d nwe=%0d ndone=%0d",
                               op, addr, r_err, r_nerr, r_nre, r_nwe, r_ndone);
        end
      end else begin
        expw   = model_word(op, addr, ref_mem[idx], wd);
        exp_re = (op == 2'b10) ? -1 : 1;
        exp_we = (op == 2'b10) ? 1 : 3;
        ref_mem[idx] = expw;
        checks++;
        if ({r_re, r_we, r_done, r_nwe, r_nerr} !== {exp_re, exp_we, exp_we + 1, 32'sd1, 32'sd0}) begin
          failures++; $display("FAIL rand_timing op=%0d addr=%h: re=%0d we=%0d done=%0d nwe=%0d, want %0d %0d %0d 1",
                               op, addr, r_re, r_we, r_done, r_nwe, exp_re, exp_we, exp_we + 1);
        end
        checks++;
        if ({r_we_addr, r_we_data, mem[idx]} !== {addr & 32'hFFFF_FFFC, expw, expw}) begin
          failures++; $display("FAIL rand_data op=%0d addr=%h: waddr=%h wdata=%h mem=%h, want %h",
                               op, addr, r_we_addr, r_we_data, mem[idx], expw);
        end
        if (op != 2'b10) begin
          checks++;
          if (r_re_addr !== r_we_addr) begin
            failures++; $display("FAIL rand_addr_hold addr=%h: at re %h at we %h", addr, r_re_addr, r_we_addr);
          end
        end
      end
    end
    checks++;
    if (overlap !== 0) begin
      failures++; $display("FAIL re_we_overlap: got %0d cycles, want 0", overlap);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_errors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_store_ctrl.md
DM_STORE_CTRL -- requirements
Module: dm_store_ctrl

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-002 Port rst, input, 1: reset, asynchronous and active-high.
REQ-003 Port st_req, input, 1: store request, sampled only in IDLE.
REQ-004 Port st_op, input, 2: store width; 00=SB, 01=SH, 10=SW, 11=reserved.
REQ-005 Port st_addr, input, 32: byte address of the store.
REQ-006 Port st_wdata, input, 32: rs2 store data, right-justified.
REQ-007 Port mem_addr, output, 32: word-aligned memory address, {addr_q[31:2],2'b00}.
REQ-008 Port mem_re, output, 1: memory read strobe; the memory returns mem_rdata on the cycle after mem_re.
REQ-009 Port mem_rdata, input, 32: memory read data.
REQ-010 Port mem_we, output, 1: full-word write strobe.
REQ-011 Port mem_wdata, output, 32: full word to write.
REQ-012 Port st_busy, output, 1: high in every state except IDLE.
REQ-013 Port st_done, output, 1: one-cycle pulse when a store completes.
REQ-014 Port st_err, output, 1: one-cycle pulse when a store is rejected (misaligned or reserved op).

Function
REQ-015 FSM states SHALL be IDLE, RD, MRG, WR, DONE, ERR.
REQ-016 In IDLE with st_req=1, the block SHALL register st_op, st_addr and st_wdata into op_q, addr_q and data_q.
REQ-017 On a request, the next state SHALL be selected as follows:
- ERR if st_op=11, or SH with st_addr[0]=1, or SW with st_addr[1:0]!=00;
- WR for an aligned SW;
- RD for SB, and for SH with st_addr[0]=0.
REQ-018 RD SHALL drive mem_re=1 for exactly one cycle, then go to MRG.
REQ-019 MRG SHALL latch the merged word into mem_wdata, then go to WR.
- SB: byte lane addr_q[1:0] of mem_rdata is replaced by data_q[7:0].
- SH: halfword lane addr_q[1] of mem_rdata is replaced by data_q[15:0].
- Lanes are little-endian (lane 0 = bits 7:0).
REQ-020 For SW, mem_wdata SHALL equal data_q, loaded at request capture.
REQ-021 WR SHALL drive mem_we=1 for exactly one cycle, then go to DONE.
REQ-022 DONE SHALL drive st_done=1 for one cycle, then return to IDLE.
REQ-023 ERR SHALL drive st_err=1 for one cycle with mem_re and mem_we held low, then return to IDLE.
REQ-024 Latency, counted from the request edge (cycle 0):
- SW: mem_we in cycle 1, st_done in cycle 2.
- SB/SH: mem_re in cycle 1, mem_we in cycle 3, st_done in cycle 4.
- Rejected store: st_err in cycle 1.
REQ-025 st_req SHALL be ignored while st_busy=1; no queuing.
REQ-026 A new request SHALL be accepted in the IDLE cycle that directly follows DONE or ERR.
REQ-027 mem_addr SHALL hold constant from RD through WR.
REQ-028 mem_re and mem_we SHALL never be high in the same cycle.
REQ-029 Unused upper bits of st_wdata (31:8 for SB, 31:16 for SH) SHALL NOT affect memory contents.

Reset
REQ-030 While rst=1, the block SHALL immediately, without a clock edge:
- set state=IDLE;
- drive mem_re, mem_we, st_busy, st_done and st_err to 0;
- clear mem_addr, mem_wdata, addr_q, data_q and op_q to 0.
REQ-031 Reset asserted mid-operation (including during WR) SHALL abort the store with no further memory strobe; the first request after reset is processed normally.

Verification
REQ-032 SW: addr=0x100, wdata=0xDEADBEEF -> cycle 1: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; cycle 2: st_done=1.
REQ-033 SB: addr=0x203, wdata=0xFFFFFFAA, memory word 0x11223344 -> mem_re in cycle 1; mem_we in cycle 3 with mem_wdata=0xAA223344, mem_addr=0x200; st_done in cycle 4.
REQ-034 SH: addr=0x202, wdata=0x0000BEEF, memory word 0x11223344 -> mem_wdata=0xBEEF3344. SH at addr=0x201 -> st_err pulse in cycle 1, no mem_re, no mem_we.
REQ-035 st_op=11 or SW at addr=0x102 -> st_err=1 for one cycle; mem_we stays 0.
REQ-036 Second st_req pulsed during a busy SB -> ignored; exactly one mem_we and one st_done are seen.
REQ-037 rst asserted in MRG -> mem_we never asserts, outputs are 0 asynchronously; after release, an SW completes with REQ-032 timing.
